// File: rtl/cordic_pkg.sv
// Shared constants and types for the time-shared CORDIC atan2 engine.
// Angles are Q3.12 radians (pi = 12868); the engine reads ATAN_TAB by
// micro-rotation index.
package cordic_pkg;

    // Angle and requester operand widths
    localparam int ANGLE_W  = 16;
    localparam int IN_W     = 16;
    localparam int MAX_ITER = 12;

    // Angle constants, Q3.12 radians
    localparam logic signed [ANGLE_W-1:0] PI_HALF = 16'sd6434;
    localparam logic signed [ANGLE_W-1:0] PI      = 16'sd12868;

    // Inverse CORDIC gain 1/K = 0.60725 in Q0.16
    localparam logic [15:0] K_INV = 16'd39797;

    // atan(2^-i) in Q3.12, i = 0..11
    localparam logic signed [ANGLE_W-1:0] ATAN_TAB [0:MAX_ITER-1] = '{
        16'sd3217, 16'sd1899, 16'sd1003, 16'sd509,
        16'sd256,  16'sd128,  16'sd64,   16'sd32,
        16'sd16,   16'sd8,    16'sd4,    16'sd2
    };

    // Engine control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Table lookup that returns 0 for indices past the end of the table
    function automatic logic signed [ANGLE_W-1:0] atan_entry(input logic [3:0] i);
        logic signed [ANGLE_W-1:0] t;
        t = '0;
        if (i < 4'(MAX_ITER)) begin
            t = ATAN_TAB[i];
        end
        return t;
    endfunction

endpackage

// File: rtl/cordic_rr_arb.sv
// Combinational round-robin arbiter: grants the first asserted request
// found searching upward from ptr, wrapping modulo N. The one-hot grant,
// its index and an "any granted" flag are all derived from the same search.
// The pointer register lives in the parent.
module cordic_rr_arb #(
    parameter int N   = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_any
);

    logic [PW-1:0] idx;

    // Search from ptr upward; the first hit wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_atan_sched.sv
// Shared iterative CORDIC vectoring engine with round-robin requester
// scheduling. One accepted (x,y) vector is quadrant pre-rotated into the
// right half-plane, then refined by one micro-rotation per cycle; the
// accumulated angle is returned tagged with the requester index.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is the arbiter grant while IDLE (it may depend
// combinationally on req_valid) and zero otherwise; rsp_valid and all
// response fields are held stable until rsp_ready is seen.
//
// Optional build macro CORDIC_MAG_OUT_EN adds the gain-compensated
// magnitude output rsp_mag.
module cordic_atan_sched
    import cordic_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ITERATIONS = 12,
    parameter int IW         = 18,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [16*NUM_REQ-1:0]     req_x,
    input  logic [16*NUM_REQ-1:0]     req_y,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic signed [ANGLE_W-1:0] rsp_angle,
`ifdef CORDIC_MAG_OUT_EN
    output logic [15:0]               rsp_mag,
`endif
    output logic [1:0]                dbg_state
);

    localparam int SBW = IDW + 4;

    state_t state;
    state_t state_next;

    logic [IDW-1:0]            rr_ptr;
    logic [3:0]                iter_cnt;
    logic signed [IW-1:0]      x_q;
    logic signed [IW-1:0]      y_q;
    logic signed [ANGLE_W-1:0] z_q;
    logic                      zero_q;

    logic [NUM_REQ-1:0]        grant;
    logic [IDW-1:0]            grant_idx;
    logic                      grant_any;
    logic                      accept;
    logic                      last_iter;

    logic [SBW-1:0]            sel_base;
    logic signed [IN_W-1:0]    sel_x;
    logic signed [IN_W-1:0]    sel_y;
    logic signed [IW-1:0]      ext_x;
    logic signed [IW-1:0]      ext_y;
    logic signed [IW-1:0]      x_ld;
    logic signed [IW-1:0]      y_ld;
    logic signed [ANGLE_W-1:0] z_ld;
    logic                      zero_ld;

    logic signed [IW-1:0]      x_sh;
    logic signed [IW-1:0]      y_sh;
    logic signed [ANGLE_W-1:0] t_cur;
    logic signed [IW-1:0]      x_nx;
    logic signed [IW-1:0]      y_nx;
    logic signed [ANGLE_W-1:0] z_nx;

    cordic_rr_arb #(
        .N (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign dbg_state = state;
    assign accept    = (state == IDLE) && grant_any;
    assign last_iter = (iter_cnt == 4'(ITERATIONS - 1));

    // Granted requester's operands, sign-extended to the datapath width
    assign sel_base = {grant_idx, 4'b0000};
    assign sel_x    = req_x[sel_base +: IN_W];
    assign sel_y    = req_y[sel_base +: IN_W];
    assign ext_x    = {{(IW-IN_W){sel_x[IN_W-1]}}, sel_x};
    assign ext_y    = {{(IW-IN_W){sel_y[IN_W-1]}}, sel_y};
    assign zero_ld  = (sel_x == '0) && (sel_y == '0);

    // Quadrant pre-rotation: fold left half-plane vectors by +/-90 degrees
    always_comb begin
        x_ld = ext_x;
        y_ld = ext_y;
        z_ld = '0;
        if (sel_x[IN_W-1]) begin
            if (!sel_y[IN_W-1]) begin
                x_ld = ext_y;
                y_ld = -ext_x;
                z_ld = PI_HALF;
            end else begin
                x_ld = -ext_y;
                y_ld = ext_x;
                z_ld = -PI_HALF;
            end
        end
    end

    // One vectoring micro-rotation driving y toward zero; all terms use
    // the current register values so the three updates are simultaneous
    always_comb begin
        x_sh  = x_q >>> iter_cnt;
        y_sh  = y_q >>> iter_cnt;
        t_cur = atan_entry(iter_cnt);
        if (!y_q[IW-1] && (y_q != '0)) begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + t_cur;
        end else begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - t_cur;
        end
    end

`ifdef CORDIC_MAG_OUT_EN
    localparam int MW = IW + 17;

    logic signed [MW-1:0] mag_prod;
    logic signed [MW-1:0] mag_scaled;
    logic [15:0]          mag_sat;

    assign mag_prod   = MW'(x_nx) * MW'($signed({1'b0, K_INV}));
    assign mag_scaled = mag_prod >>> 16;

    // Gain-compensated magnitude, clamped into the unsigned 16-bit range
    always_comb begin
        mag_sat = mag_scaled[15:0];
        if (mag_scaled < 0) begin
            mag_sat = '0;
        end else if (mag_scaled > MW'(65535)) begin
            mag_sat = 16'hFFFF;
        end
    end

    // Magnitude result register, loaded on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_mag <= '0;
        end else if ((state == ITER) && last_iter) begin
            rsp_mag <= zero_q ? '0 : mag_sat;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and requester-ready decode
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (grant_any) begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath, scheduler pointer and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            iter_cnt  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            zero_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_angle <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_id   <= grant_idx;
                        x_q      <= x_ld;
                        y_q      <= y_ld;
                        z_q      <= z_ld;
                        zero_q   <= zero_ld;
                        iter_cnt <= '0;
                        rr_ptr   <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0
                                                                     : grant_idx + 1'b1;
                    end
                end
                ITER: begin
                    x_q      <= x_nx;
                    y_q      <= y_nx;
                    z_q      <= z_nx;
                    iter_cnt <= iter_cnt + 4'd1;
                    if (last_iter) begin
                        iter_cnt  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_angle <= zero_q ? '0 : z_nx;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_atan_sched.sv
// Bench for cordic_atan_sched: per-requester vector queues drive the
// request ports; a negedge monitor predicts round-robin grants and pushes
// expected responses (atan2 from real arithmetic) into exp_q, then checks
// response timing, content and hold behaviour.
module tb_cordic_atan_sched;
    import cordic_pkg::*;

    localparam int NR      = 4;
    localparam int ITERS   = 12;
    localparam int IDW     = $clog2(NR);
    localparam int ANG_TOL = 6;
    localparam int MAG_TOL = 12;
    localparam int W       = 41;   // {exact, id[7:0], angle[15:0], mag[15:0]}
    localparam int DEPTH   = 128;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NR-1:0]         req_valid;
    logic [NR-1:0]         req_ready;
    logic [16*NR-1:0]      req_x;
    logic [16*NR-1:0]      req_y;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic signed [15:0]    rsp_angle;
    logic [1:0]            dbg_state;
`ifdef CORDIC_MAG_OUT_EN
    logic [15:0]           rsp_mag;
`endif

    logic [15:0] drv_x [NR];
    logic [15:0] drv_y [NR];

    // clock / reset
    always #5 clk = ~clk;

    cordic_atan_sched #(
        .NUM_REQ    (NR),
        .ITERATIONS (ITERS),
        .IW         (18)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_angle (rsp_angle),
`ifdef CORDIC_MAG_OUT_EN
        .rsp_mag   (rsp_mag),
`endif
        .dbg_state (dbg_state)
    );

    for (genvar gi = 0; gi < NR; gi++) begin : g_pack
        assign req_x[16*gi +: 16] = drv_x[gi];
        assign req_y[16*gi +: 16] = drv_y[gi];
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];
    int  src_xm [NR][DEPTH];
    int  src_ym [NR][DEPTH];
    int  head   [NR];
    int  tail   [NR];
    int  rdy_mode = 0;          // 0: always ready, 1: random, 2: held low
    bit  busy = 1'b0;
    int  acc_cyc = 0;
    int  rr_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req, input int tol);
        checks++;
        if ((act - req > tol) || (req - act > tol)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
        end
    endtask

    // Reference: atan2 and vector length in plain real arithmetic
    function automatic logic [W-1:0] make_exp(input int id, input int x, input int y);
        real a;
        real m;
        int  ang;
        int  mag;
        logic ex;
        if (x == 0 && y == 0) begin
            ex = 1'b1; ang = 0; mag = 0;
        end else begin
            ex  = 1'b0;
            a   = $atan2(real'(y), real'(x)) * 4096.0;
            m   = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
            ang = $rtoi(a + ((a >= 0.0) ? 0.5 : -0.5));
            mag = $rtoi(m + 0.5);
        end
        return {ex, 8'(id), 16'(ang), 16'(mag)};
    endfunction

    function automatic bit idle_now();
        bit r;
        r = !busy && (exp_q.size() == 0);
        for (int i = 0; i < NR; i++) if (head[i] != tail[i]) r = 1'b0;
        return r;
    endfunction

    // driver tasks
    task automatic push(input int r, input int x, input int y);
        src_xm[r][tail[r]] = x;
        src_ym[r][tail[r]] = y;
        tail[r]++;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!idle_now() && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, idle_now(), 1, 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_reset(input int n);
        #1 rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Requester and consumer pins follow the queues, updated after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (head[i] < tail[i]) begin
                    req_valid[i] = 1'b1;
                    drv_x[i] = 16'(src_xm[i][head[i]]);
                    drv_y[i] = 16'(src_ym[i][head[i]]);
                end else begin
                    req_valid[i] = 1'b0;
                    drv_x[i] = 16'($urandom);
                    drv_y[i] = 16'($urandom);
                end
            end
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // scoreboard monitor
    logic [NR-1:0]  exp_rdy;
    logic [W-1:0]   e;
    bit             exp_v;
    bit             hold_vld = 1'b0;
    logic [IDW-1:0] hold_id;
    logic [15:0]    hold_ang;
    logic [15:0]    hold_mag;

    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0;
            rr_m = 0;
            hold_vld = 1'b0;
            exp_q.delete();
        end else begin
            int g;
            check("req_ready_onehot", $onehot0(req_ready), 1, 0);
            g = -1;
            exp_rdy = '0;
            if (!busy) begin
                for (int k = 0; k < NR; k++) begin
                    if (g < 0 && req_valid[(rr_m + k) % NR]) g = (rr_m + k) % NR;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", req_ready, exp_rdy, 0);
            if (g >= 0) begin
                exp_q.push_back(make_exp(g, src_xm[g][head[g]], src_ym[g][head[g]]));
                head[g]++;
                rr_m    = (g + 1) % NR;
                busy    = 1'b1;
                acc_cyc = cyc;
            end else begin
                exp_v = busy && (cyc >= acc_cyc + ITERS + 1);
                check("rsp_valid", rsp_valid, exp_v, 0);
                if (hold_vld) begin
                    check("hold_rsp_id", rsp_id, hold_id, 0);
                    check("hold_rsp_angle", rsp_angle, $signed(hold_ang), 0);
`ifdef CORDIC_MAG_OUT_EN
                    check("hold_rsp_mag", rsp_mag, hold_mag, 0);
`endif
                end
                hold_vld = 1'b0;
                if (rsp_valid && exp_v && exp_q.size() > 0) begin
                    e = exp_q[0];
                    check("rsp_id", rsp_id, e[39:32], 0);
                    check("rsp_angle", rsp_angle, $signed(e[31:16]), e[40] ? 0 : ANG_TOL);
`ifdef CORDIC_MAG_OUT_EN
                    check("rsp_mag", rsp_mag, e[15:0], e[40] ? 0 : MAG_TOL);
`endif
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        busy = 1'b0;
                    end else begin
                        hold_vld = 1'b1;
                        hold_id  = rsp_id;
                        hold_ang = rsp_angle;
`ifdef CORDIC_MAG_OUT_EN
                        hold_mag = rsp_mag;
`endif
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic signed [15:0] rx;
        logic signed [15:0] ry;
        int n;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            head[i] = 0; tail[i] = 0; drv_x[i] = '0; drv_y[i] = '0;
        end
        hold_id = '0; hold_ang = '0; hold_mag = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", dbg_state, 0, 0);
        check("reset_rsp_valid", rsp_valid, 0, 0);
        check("reset_rsp_id", rsp_id, 0, 0);
        check("reset_rsp_angle", rsp_angle, 0, 0);

        // directed vectors, including axis and zero cases
        @(posedge clk);
        push(2, 1000, 1000);
        wait_idle("drain_single", 100);
        push(0, -1000, 0);
        push(1, 0, -500);
        push(3, 0, 0);
        wait_idle("drain_axes", 200);

        // all requesters contend from reset: order 0,1,2,3,0,...
        pulse_reset(2);
        for (int i = 0; i < NR; i++) begin
            push(i, 3000 * (i + 1) - 7000, 9000 - 4100 * i);
            push(i, -2500 * (i + 1), 1234 - 3000 * i);
        end
        wait_idle("drain_contend", 400);

        // response held off for 5 cycles with a second request waiting
        rdy_mode = 2;
        push(1, 3000, -2000);
        push(3, -1500, 2500);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("hold_rsp_seen", rsp_valid, 1, 0);
        repeat (5) @(posedge clk);
        rdy_mode = 0;
        wait_idle("drain_hold", 200);

        // reset during ITER cycle 6 drops the transaction and the pointer
        push(1, 2000, 2000);
        n = 0;
        while (!busy && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("abort_accept_seen", busy, 1, 0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        push(3, -4000, -3000);
        push(0, 5000, 100);
        @(negedge clk);
        check("abort_state_idle", dbg_state, 0, 0);
        check("abort_rsp_valid", rsp_valid, 0, 0);
        wait_idle("drain_abort", 200);

        // randomized traffic with random backpressure
        rdy_mode = 1;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                rx = '0; ry = '0;
            end else begin
                do begin
                    rx = 16'($urandom);
                    ry = 16'($urandom);
                end while ((rx < 4096 && rx > -4096) && (ry < 4096 && ry > -4096));
            end
            push($urandom_range(0, NR - 1), rx, ry);
            repeat ($urandom_range(0, 8)) @(posedge clk);
        end
        wait_idle("drain_random", 3000);
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // final report on a runaway simulation
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cordic_atan_sched.md
Name: cordic_atan_sched

Overview:
- Shared iterative CORDIC vectoring engine plus a round-robin scheduler.
- Up to NUM_REQ requesters submit (x,y) vectors. One engine computes atan2(y,x) at one micro-rotation per cycle and returns the angle tagged with the requester ID.
- Sits between the sensor/steering front-ends and the control loop, replacing per-requester combinational atan instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ITERATIONS, 12, micro-rotations per transaction (1..12).
- IW, 18, internal signed width of x/y datapath registers.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_x  in  16*NUM_REQ  flattened signed x, requester i at bits [16i+15:16i].
- req_y  in  16*NUM_REQ  flattened signed y, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester owning the result.
- rsp_angle  out  16  signed angle, Q3.12 radians (pi = 12868).

Behaviour:
- Interface: one clock, clk; reset synchronous active-high, rst.
- FSM states: IDLE, ITER, DONE.
- Reset (any state, including mid-ITER or DONE):
  - state to IDLE; rr_ptr to 0; iteration counter to 0; rsp_valid to 0; rsp_id to 0; rsp_angle to 0.
  - Any in-flight transaction is dropped silently.
- IDLE and grant:
  - grant = first asserted req_valid searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready = grant, only while in IDLE; all zero in other states. req_ready may depend combinationally on req_valid.
  - Handshake: accept when req_valid[g] & req_ready[g].
  - On accept: latch the ID, load the pre-rotated operands, set rr_ptr = (g+1) mod NUM_REQ, go to ITER.
- Pre-rotation at load (inputs sign-extended to IW):
  - x>=0: x0=x, y0=y, z0=0.
  - x<0, y>=0: x0=y, y0=-x, z0=+6434.
  - x<0, y<0: x0=-y, y0=x, z0=-6434.
  - x==0 and y==0: zero flag set; result forced to 0.
- ITER: iteration i = 0..ITERATIONS-1, one per cycle, all updates from previous-cycle values (simultaneous, not sequential):
  - y>0: x += y>>>i; y -= x>>>i; z += T[i].
  - y<=0: x -= y>>>i; y += x>>>i; z -= T[i].
  - Shifts are arithmetic (floor).
  - After the last iteration go to DONE.
- Atan table T, Q3.12: 3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2.
- Widths: IW=18 covers the sqrt2 * 32768 * 1.647 peak magnitude. z held in 16 bits; no overflow possible.
- DONE:
  - rsp_valid=1; rsp_angle=z (or 0 if zero flag); rsp_id held.
  - All response outputs stable while rsp_ready=0.
  - On rsp_ready go to IDLE.
- Latency: accept at cycle T, rsp_valid first high at T+1+ITERATIONS.
- Throughput: one transaction per ITERATIONS+2 cycles minimum (IDLE bubble after DONE).
- Requester inputs are sampled only at accept; changes afterwards have no effect.

Optional Feature:
- Macro CORDIC_MAG_OUT_EN.
- Defined:
  - Adds output rsp_mag (16, unsigned) = (final x * 39797) >> 16, saturated to 65535. This compensates the CORDIC gain (1/K = 0.60725 in Q0.16).
  - Registered on entry to DONE, follows the same valid/hold rules, reset value 0, 0 when the zero flag is set.
- Undefined: port and multiplier absent; all other behaviour identical.

Decomposition:
- Package cordic_pkg:
  - atan table constant array (Q3.12);
  - PI_HALF=6434, PI=12868;
  - K_INV=39797;
  - FSM state enum;
  - angle/internal width localparams.
- Sub-module cordic_rr_arb: combinational round-robin grant from req_valid and rr_ptr, one-hot output. The pointer register stays in the parent.

Test Plan:
- Single request x=1000, y=1000 on requester 2, rsp_ready=1 -> rsp_valid at T+13, rsp_id=2, rsp_angle 3217 +/-6.
- x=-1000, y=0 -> rsp_angle 12868 +/-6.
- x=0, y=-500 -> rsp_angle -6434 +/-6.
- x=0, y=0 -> rsp_angle exactly 0.
- All 4 requesters valid continuously from reset, distinct vectors -> grants and rsp_id sequence 0,1,2,3,0; each rsp_angle matches its own vector; req_ready never multi-hot.
- rsp_ready held low 5 cycles in DONE -> rsp_valid/rsp_id/rsp_angle stable, req_ready all 0; accept resumes the cycle after the rsp_ready handshake.
- rst pulsed at ITER cycle 6 -> next cycle IDLE, rsp_valid=0, rr_ptr=0; no response for the aborted transaction; next request on requester 0 is granted first.
